seq_adder_ctrl: RTL and testbench

//  Sequencer for the bit-serial full-adder cell (registered carry; load=1 selects cin into carry FF).

---
 rtl/seq_adder_ctrl.sv | 130 +++++++++++++
 tb/tb_seq_adder_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_ctrl.sv
// Sequencer that drives a bit-serial full-adder cell LSB-first and returns a parallel sum/carry.
// Optional two's-complement overflow output ovf_out is enabled by defining SEQ_ADD_OVF_EN.
module seq_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
`ifdef SEQ_ADD_OVF_EN
  output logic             ovf_out,
`endif
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_cin,
  output logic             ser_load,
  input  logic             ser_s,
  input  logic             ser_c
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_DONE} state_t;

  state_t           state, next;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    cnt;
  logic             cin_r;
  logic             last;
`ifdef SEQ_ADD_OVF_EN
  logic             a_msb, b_msb;
`endif

  // The final sum bit comes straight from the cell, so the full word is assembled combinationally
  assign sum_next = {ser_s, sum_sr};
  assign last     = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next     = state;
    busy     = 1'b1;
    done     = 1'b0;
    ser_a    = 1'b0;
    ser_b    = 1'b0;
    ser_cin  = 1'b0;
    ser_load = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) next = S_LOAD;
      end
      S_LOAD: begin
        ser_load = 1'b1;
        ser_cin  = cin_r;
        next     = S_ADD;
      end
      S_ADD: begin
        ser_a = a_sr[0];
        ser_b = b_sr[0];
        if (last) next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      cnt      <= '0;
      cin_r    <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      ovf_out  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            cin_r <= cin_in;
            cnt   <= '0;
`ifdef SEQ_ADD_OVF_EN
            a_msb <= a_in[WIDTH-1];
            b_msb <= b_in[WIDTH-1];
`endif
          end
        end
        S_ADD: begin
          sum_sr <= sum_next[WIDTH-1:1];
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          // Results land on the edge entering DONE so they are visible while done is high
          if (last) begin
            sum_out  <= sum_next;
            cout_out <= ser_c;
`ifdef SEQ_ADD_OVF_EN
            ovf_out  <= (a_msb == b_msb) && (ser_s != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder_ctrl.sv
// Directed bench for seq_adder_ctrl with a behavioural serial full-adder cell attached.
// Define SEQ_ADD_OVF_EN to also exercise the overflow output.
module tb_seq_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic             cin_in;
  logic             busy, done, cout_out;
  logic [WIDTH-1:0] sum_out;
  logic             ser_a, ser_b, ser_cin, ser_load, ser_s, ser_c;
`ifdef SEQ_ADD_OVF_EN
  logic             ovf_out;
`endif
  logic             cell_cf;

  int n_cmp = 0;
  int n_err = 0;

  seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
`ifdef SEQ_ADD_OVF_EN
    .ovf_out(ovf_out),
`endif
    .ser_a(ser_a), .ser_b(ser_b), .ser_cin(ser_cin), .ser_load(ser_load),
    .ser_s(ser_s), .ser_c(ser_c)
  );

  always #5 clk = ~clk;

  // Serial full-adder cell: registered carry, load selects cin into the carry FF
  assign ser_s = ser_a ^ ser_b ^ cell_cf;
  assign ser_c = (ser_a & ser_b) | (cell_cf & (ser_a ^ ser_b));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cell_cf <= 1'b0;
    else      cell_cf <= ser_load ? ser_cin : ser_c;
  end

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    @(negedge clk);
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (sum_out !== 8'h00) begin n_err++; $display("[TB] FAIL reset_sum: got %h expected 00", sum_out); end
    n_cmp++; if (cout_out !== 1'b0) begin n_err++; $display("[TB] FAIL reset_cout: got %b expected 0", cout_out); end
    n_cmp++;
    if ({ser_a, ser_b, ser_cin, ser_load} !== 4'b0000) begin
      n_err++; $display("[TB] FAIL reset_ser: got %b expected 0000", {ser_a, ser_b, ser_cin, ser_load});
    end
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL post_reset_idle: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    start_op(8'h35, 8'h4A, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL basic_busy cycle %0d: got %b expected 1", k, busy); end
      n_cmp++;
      if (done !== (k == 10)) begin
        n_err++; $display("[TB] FAIL basic_done cycle %0d: got %b expected %b", k, done, (k == 10));
      end
      if (k == 1) begin
        n_cmp++;
        if ({ser_load, ser_cin} !== 2'b10) begin
          n_err++; $display("[TB] FAIL basic_load: got %b expected 10", {ser_load, ser_cin});
        end
      end
      if (k < 10) @(negedge clk);
    end
    n_cmp++; if (sum_out !== 8'h7F) begin n_err++; $display("[TB] FAIL basic_sum: got %h expected 7f", sum_out); end
    n_cmp++; if (cout_out !== 1'b0) begin n_err++; $display("[TB] FAIL basic_cout: got %b expected 0", cout_out); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy); end
    n_cmp++; if (sum_out !== 8'h7F) begin n_err++; $display("[TB] FAIL basic_hold: got %h expected 7f", sum_out); end
  endtask

  task automatic test_carry();
    int i;
    start_op(8'hFF, 8'h01, 1'b0);
    for (i = 1; i < 40 && done !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (i != 10) begin n_err++; $display("[TB] FAIL carry1_latency: got %0d expected 10", i); end
    n_cmp++; if (sum_out !== 8'h00) begin n_err++; $display("[TB] FAIL carry1_sum: got %h expected 00", sum_out); end
    n_cmp++; if (cout_out !== 1'b1) begin n_err++; $display("[TB] FAIL carry1_cout: got %b expected 1", cout_out); end
    start_op(8'hFF, 8'h00, 1'b1);
    for (i = 1; i < 40 && done !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (i != 10) begin n_err++; $display("[TB] FAIL carry2_latency: got %0d expected 10", i); end
    n_cmp++; if (sum_out !== 8'h00) begin n_err++; $display("[TB] FAIL carry2_sum: got %h expected 00", sum_out); end
    n_cmp++; if (cout_out !== 1'b1) begin n_err++; $display("[TB] FAIL carry2_cout: got %b expected 1", cout_out); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    int done_k = 0;
    logic [WIDTH-1:0] got_sum = '0;
    logic got_cout = 1'b0;
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin ndone++; done_k = k; got_sum = sum_out; got_cout = cout_out; end
      if (k == 1) start = 1'b0;
      if (k == 3) begin start = 1'b1; a_in = 8'h11; b_in = 8'h22; cin_in = 1'b1; end
      if (k == 5) start = 1'b0;
    end
    n_cmp++; if (ndone != 1) begin n_err++; $display("[TB] FAIL busy_done_count: got %0d expected 1", ndone); end
    n_cmp++; if (done_k != 10) begin n_err++; $display("[TB] FAIL busy_done_cycle: got %0d expected 10", done_k); end
    n_cmp++; if (got_sum !== 8'h46) begin n_err++; $display("[TB] FAIL busy_sum: got %h expected 46", got_sum); end
    n_cmp++; if (got_cout !== 1'b0) begin n_err++; $display("[TB] FAIL busy_cout: got %b expected 0", got_cout); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL busy_end_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int i;
    start_op(8'hAA, 8'h55, 1'b0);
    for (int k = 2; k <= 5; k++) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (sum_out !== 8'h00) begin n_err++; $display("[TB] FAIL abort_sum: got %h expected 00", sum_out); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_cmp++; if (ndone != 0) begin n_err++; $display("[TB] FAIL abort_no_done: got %0d expected 0", ndone); end
    start_op(8'h0F, 8'h01, 1'b0);
    for (i = 1; i < 40 && done !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (i != 10) begin n_err++; $display("[TB] FAIL after_abort_latency: got %0d expected 10", i); end
    n_cmp++; if (sum_out !== 8'h10) begin n_err++; $display("[TB] FAIL after_abort_sum: got %h expected 10", sum_out); end
    n_cmp++; if (cout_out !== 1'b0) begin n_err++; $display("[TB] FAIL after_abort_cout: got %b expected 0", cout_out); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int prev_k = 0;
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h80; cin_in = 1'b1; start = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        n_cmp++;
        if (k - prev_k != ((ndone == 1) ? 10 : 11)) begin
          n_err++; $display("[TB] FAIL b2b_spacing done %0d: got %0d expected %0d", ndone, k - prev_k, (ndone == 1) ? 10 : 11);
        end
        n_cmp++;
        if ({cout_out, sum_out} !== 9'h101) begin
          n_err++; $display("[TB] FAIL b2b_result done %0d: got %h expected 101", ndone, {cout_out, sum_out});
        end
        prev_k = k;
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (ndone != 3) begin n_err++; $display("[TB] FAIL b2b_count: got %0d expected 3", ndone); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_end_idle: got %b expected 0", busy); end
  endtask

`ifdef SEQ_ADD_OVF_EN
  task automatic test_overflow();
    int i;
    start_op(8'h7F, 8'h01, 1'b0);
    for (i = 1; i < 40 && done !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (sum_out !== 8'h80) begin n_err++; $display("[TB] FAIL ovf1_sum: got %h expected 80", sum_out); end
    n_cmp++; if (ovf_out !== 1'b1) begin n_err++; $display("[TB] FAIL ovf1_flag: got %b expected 1", ovf_out); end
    start_op(8'h80, 8'hFF, 1'b0);
    for (i = 1; i < 40 && done !== 1'b1; i++) @(negedge clk);
    n_cmp++; if ({cout_out, sum_out} !== 9'h17F) begin n_err++; $display("[TB] FAIL ovf2_result: got %h expected 17f", {cout_out, sum_out}); end
    n_cmp++; if (ovf_out !== 1'b1) begin n_err++; $display("[TB] FAIL ovf2_flag: got %b expected 1", ovf_out); end
    start_op(8'h05, 8'h03, 1'b0);
    for (i = 1; i < 40 && done !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (sum_out !== 8'h08) begin n_err++; $display("[TB] FAIL ovf3_sum: got %h expected 08", sum_out); end
    n_cmp++; if (ovf_out !== 1'b0) begin n_err++; $display("[TB] FAIL ovf3_flag: got %b expected 0", ovf_out); end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
`ifdef SEQ_ADD_OVF_EN
    test_overflow();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
